mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the multicycle MIPS datapath.
- Sits directly downstream of the ALU source-operand muxes and consumes the selected A/B operand words.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, one bit per cycle, and holds the results in the architectural HI/LO registers.
- The control FSM starts an operation and stalls on busy until done.

---
 rtl/mult_div_unit.sv | 140 ++++++++++++++
 tb/tb_mult_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle, HI/LO result registers.
// Optional MTHI/MTLO write port enabled by defining MULTDIV_HILO_WRITE_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULTDIV_HILO_WRITE_EN
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic               is_div;
    logic               is_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               a_neg;

    assign a_neg = ~op[0] & A[WIDTH-1];

    // One shift-add / restoring-divide step, plus sign fix-up of the final result
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next = {add_sum, acc[WIDTH-1:1]};
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        if (!trial[WIDTH])
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        prod = (is_signed && (sa ^ sb)) ? -acc : acc;
        quot = (is_signed && (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = (is_signed && sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered busy/done/dz and the HI/LO result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
        end else begin
`ifdef MULTDIV_HILO_WRITE_EN
            if (hilo_we && !busy) begin
                if (hilo_sel)
                    hi <= hilo_wdata;
                else
                    lo <= hilo_wdata;
            end
`endif
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div    <= op[1];
                        is_signed <= ~op[0];
                        sa        <= a_neg;
                        sb        <= ~op[0] & B[WIDTH-1];
                        mag_a     <= a_neg ? -A : A;
                        mag_b     <= (~op[0] & B[WIDTH-1]) ? -B : B;
                        // Lower half holds the value consumed bit by bit
                        if (op[1])
                            acc <= {{WIDTH{1'b0}}, a_neg ? -A : A};
                        else
                            acc <= {{WIDTH{1'b0}}, (~op[0] & B[WIDTH-1]) ? -B : B};
                        cnt   <= CW'(WIDTH);
                        dz    <= 1'b0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div && mag_b == '0) begin
                        // Divide by zero returns the original dividend in HI
                        hi <= (is_signed && sa) ? -mag_a : mag_a;
                        lo <= '1;
                        dz <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem;
                        lo <= quot;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed plan cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULTDIV_HILO_WRITE_EN
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .A(A),
        .B(B),
`ifdef MULTDIV_HILO_WRITE_EN
        .hilo_we(hilo_we),
        .hilo_sel(hilo_sel),
        .hilo_wdata(hilo_wdata),
`endif
        .busy(busy),
        .done(done),
        .dz(dz),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: MIPS HI/LO semantics from 64-bit integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sa_v, sb_v, p, q, r;
        logic [63:0] up;
        sa_v = longint'($signed(a));
        sb_v = longint'($signed(b));
        z = 1'b0;
        case (o)
            2'b00: begin p = sa_v * sb_v; h = p[63:32]; l = p[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF; z = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa_v / sb_v; r = sa_v % sb_v; h = r[31:0]; l = q[31:0];
                end else begin
                    h = a % b; l = a / b;
                end
            end
        endcase
    endfunction

    // Starts at a negedge, returns at the negedge of the done cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, input string name);
        logic [31:0] eh, el;
        logic ez;
        int cyc, bad;
        model(o, a, b, eh, el, ez);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        cyc = 1; bad = 0;
        checks++;
        if (dz !== 1'b0) begin errors++; $display("FAIL %s dz_clear got %b want 0", name, dz); end
        while (!done && cyc < 40) begin
            if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) bad++;
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
`ifdef MULTDIV_HILO_WRITE_EN
            hilo_we = (cyc == 5);
            hilo_sel = 1'($urandom);
            hilo_wdata = $urandom;
`endif
        end
        start = 1'b0;
`ifdef MULTDIV_HILO_WRITE_EN
        hilo_we = 1'b0;
`endif
        checks++;
        if (cyc !== 34) begin errors++; $display("FAIL %s latency got %0d want 34", name, cyc); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL %s busy_stable got %0d bad cycles want 0", name, bad); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
        checks++;
        if (hi !== eh) begin errors++; $display("FAIL %s hi got %h want %h", name, hi, eh); end
        checks++;
        if (lo !== el) begin errors++; $display("FAIL %s lo got %h want %h", name, lo, el); end
        checks++;
        if (dz !== ez) begin errors++; $display("FAIL %s dz got %b want %b", name, dz, ez); end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; A = $urandom; B = $urandom;
`ifdef MULTDIV_HILO_WRITE_EN
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, dz} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, dz, hi, lo);
        end
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        @(negedge clk);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_overflow");
        @(negedge clk);
        run_op(2'b11, 32'h8000_0000, 32'd3, -1, "divu_min");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, "div_b2b");
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd0, -1, "divu_zero");
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, -1, "div_zero_neg");
        run_op(2'b01, 32'd9, 32'd9, -1, "after_dz");
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        run_op(2'b01, 32'd5, 32'd6, 10, "start_ignored");
    endtask

    task automatic test_random();
        logic [31:0] sp [5];
        logic [31:0] a, b;
        sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(2'($urandom), a, b, -1, "random");
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        start = 1'b1; op = 2'b01; A = 32'h1234_5671; B = 32'h0000_0F03;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
        end
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_done got %0d active cycles want 0", seen); end
    endtask

`ifdef MULTDIV_HILO_WRITE_EN
    task automatic test_hilo_write();
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234_5678;
        @(negedge clk);
        hilo_we = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== m_lo) begin
            errors++;
            $display("FAIL hilo_write got hi=%h lo=%h want %h %h", hi, lo, 32'h1234_5678, m_lo);
        end
        m_hi = 32'h1234_5678;
        run_op(2'b01, 32'd3, 32'd4, -1, "write_while_busy");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_random();
`ifdef MULTDIV_HILO_WRITE_EN
        test_hilo_write();
`endif
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
